// File: rtl/uart_seq_pkg.sv
// ---------------------------------------------------------------------------
// uart_seq_pkg
// Shared types and constants for the UART APB sequencer.
//   seq_state_e    : sequencer FSM states
//   ADDR_*         : UART register offsets on the 5-bit APB address bus
//   is_bus_state() : true for states that own one APB transfer
// Optional feature macro used by the sequencer: UART_SEQ_RX_STATUS_EN
// ---------------------------------------------------------------------------
package uart_seq_pkg;

    typedef enum logic [2:0] {
        StCfg1,
        StCfg2,
        StIdle,
        StStat,
        StRxRd,
        StTxWr,
        StGuard
    } seq_state_e;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    function automatic logic is_bus_state(input seq_state_e st);
        return !((st == StIdle) || (st == StGuard));
    endfunction

endpackage

// File: rtl/uart_seq_rr_arb.sv
// ---------------------------------------------------------------------------
// uart_seq_rr_arb
// Two-way round-robin arbiter for the transmit requesters.
//   PCLK      in   clock
//   aresetn   in   asynchronous active-low reset
//   en        in   arbitration allowed this cycle
//   valid     in   [1:0] request valids
//   gnt       out  [1:0] one-hot grant (zero when en=0 or no valid)
//   last_gnt  out  requester granted most recently (resets to 1)
// ---------------------------------------------------------------------------
module uart_seq_rr_arb (
    input  logic       PCLK,
    input  logic       aresetn,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] gnt,
    output logic       last_gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie goes to whoever was not served last.
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

    assign last_gnt = last_q;

endmodule

// File: rtl/uart_apb_sequencer.sv
// ---------------------------------------------------------------------------
// uart_apb_sequencer
// APB3 master owning the UART register port. Programs CTRL1/CTRL2 after
// reset, then loops: receive service first, otherwise round-robin transmit
// between two byte producers. Each bus state issues exactly one transfer;
// bus outputs are registered so the first SETUP follows reset release.
// Optional feature: define UART_SEQ_RX_STATUS_EN to read STATUS before every
// RXDATA read and report {framing, overflow, parity} on rx_err.
// Ports:
//   PCLK, PRESETN                       clock, async active-low reset
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA, PRDATA, PREADY              APB3 master port to the UART
//   TXRDY, RXRDY                        UART status pins
//   req0_*/req1_*                       transmit byte producers (valid/ready)
//   rx_valid, rx_data, rx_err, rx_ready received byte to the consumer
//   cfg_done                            configuration finished (sticky)
// ---------------------------------------------------------------------------
module uart_apb_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd26,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       TXRDY,
    input  logic       RXRDY,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic [2:0] rx_err,
    input  logic       rx_ready,
    output logic       cfg_done
);

`ifdef UART_SEQ_RX_STATUS_EN
    localparam seq_state_e RX_FIRST = StStat;
`else
    localparam seq_state_e RX_FIRST = StRxRd;
`endif

    seq_state_e state_q, state_d;
    logic       guard_q, guard_d;
    logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [4:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       cfg_done_q;
    logic       xfer_done, rx_start, arb_en;
    logic [1:0] gnt;
    logic       unused_last_gnt;

    assign xfer_done = psel_q && penable_q && PREADY;
    assign rx_start  = (state_q == StIdle) && RXRDY && !rx_valid_q;
    assign arb_en    = (state_q == StIdle) && TXRDY && !rx_start;

    uart_seq_rr_arb u_arb (
        .PCLK     (PCLK),
        .aresetn  (PRESETN),
        .en       (arb_en),
        .valid    ({req1_valid, req0_valid}),
        .gnt      (gnt),
        .last_gnt (unused_last_gnt)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        unique case (state_q)
            StCfg1: if (xfer_done) state_d = StCfg2;
            StCfg2: if (xfer_done) state_d = StIdle;
            StIdle: begin
                if (rx_start) begin
                    state_d = RX_FIRST;
                end else if (|gnt) begin
                    state_d = StTxWr;
                end
            end
            StStat: if (xfer_done) state_d = StRxRd;
            StRxRd, StTxWr: begin
                if (xfer_done) begin
                    state_d = StGuard;
                    guard_d = 1'b0;
                end
            end
            StGuard: begin
                if (guard_q) state_d = StIdle;
                else         guard_d = 1'b1;
            end
            default: state_d = StCfg1;
        endcase
    end

    // Bus outputs: a new SETUP is launched on entry to a bus state (or on the
    // first cycle out of reset), so back-to-back transfers have no gap.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        if (is_bus_state(state_d) && ((state_d != state_q) || !psel_q)) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            unique case (state_d)
                StCfg1: begin
                    paddr_d  = ADDR_CTRL1;
                    pwrite_d = 1'b1;
                    pwdata_d = BAUD_VALUE[7:0];
                end
                StCfg2: begin
                    paddr_d  = ADDR_CTRL2;
                    pwrite_d = 1'b1;
                    pwdata_d = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
                end
                StStat: begin
                    paddr_d  = ADDR_STATUS;
                    pwrite_d = 1'b0;
                    pwdata_d = 8'h00;
                end
                StRxRd: begin
                    paddr_d  = ADDR_RXDATA;
                    pwrite_d = 1'b0;
                    pwdata_d = 8'h00;
                end
                StTxWr: begin
                    paddr_d  = ADDR_TXDATA;
                    pwrite_d = 1'b1;
                    pwdata_d = gnt[1] ? req1_data : req0_data;
                end
                default: begin
                    psel_d = 1'b0;
                end
            endcase
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else if (xfer_done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= StCfg1;
            guard_q   <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= 5'h00;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            cfg_done_q <= 1'b0;
        end else begin
            if ((state_q == StRxRd) && xfer_done) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= PRDATA;
            end else if (rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if ((state_q == StCfg2) && xfer_done) begin
                cfg_done_q <= 1'b1;
            end
        end
    end

`ifdef UART_SEQ_RX_STATUS_EN
    logic [2:0] err_hold_q;
    logic [2:0] rx_err_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            err_hold_q <= 3'b000;
            rx_err_q   <= 3'b000;
        end else begin
            if ((state_q == StStat) && xfer_done) begin
                err_hold_q <= PRDATA[4:2];
            end
            if ((state_q == StRxRd) && xfer_done) begin
                rx_err_q <= err_hold_q;
            end
        end
    end

    assign rx_err = rx_err_q;
`else
    assign rx_err = 3'b000;
`endif

    assign PADDR      = paddr_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign cfg_done   = cfg_done_q;

endmodule
